dt_engine_param: RTL and testbench

- Parametrised distance-transform engine for binary images of any size and packing, with selectable metric (chessboard or city-block).
- Reads a packed 1-bit-per-pixel image from the stimulus ROM and writes a PIX_W-bit distance map to the result RAM.
- Sequence: load, forward pass, backward pass. Flags after each pass let the bench check intermediate and final RAM contents.

---
 rtl/dt_engine_param.sv | 248 ++++++++++++++++++++++++
 tb/tb_dt_engine_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dt_engine_param.sv
// dt_engine_param: two-pass distance-transform engine for packed binary images.
//   A run loads the packed 1-bit image from the stimulus ROM into the result
//   RAM (object = 1, background = 0). It then does a forward raster pass and a
//   reverse raster pass using the chessboard (8-neighbour) or city-block
//   (4-neighbour) metric. The result is a PIX_W-bit distance map that
//   saturates at 2^PIX_W-1.
// Ports:
//   clk, reset (async, active-low)
//   start (one-cycle pulse; accepted in IDLE/DONE only), mode (0 chessboard, 1 city-block)
//   busy, fwpass_finish, done : run status levels
//   sti_rd / sti_addr / sti_di : ROM read port, word-addressed, MSB = lowest pixel index
//   res_rd / res_wr / res_addr / res_do / res_di : RAM port, address = row*IMG_W+col
// Memory handshake: every output is a register. The memories sample rd/addr at
// negedge, and read data is captured at the posedge that ends the read cycle.
// A write commits at the posedge that ends the write cycle. rd and wr are never
// both high in the same cycle.
module dt_engine_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_DW = 16,
  parameter int PIX_W  = 8,
  parameter int STI_AW = $clog2(IMG_W * IMG_H / STI_DW),
  parameter int RES_AW = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              fwpass_finish,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [STI_DW-1:0] sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [PIX_W-1:0]  res_do,
  input  logic [PIX_W-1:0]  res_di
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int KW   = (STI_DW > 1) ? $clog2(STI_DW) : 1;

  localparam logic [RES_AW-1:0] LAST_PIX = RES_AW'(NPIX - 1);
  localparam logic [RES_AW-1:0] OFF_W    = RES_AW'(IMG_W);
  localparam logic [RES_AW-1:0] A_ONE    = RES_AW'(1);
  localparam logic [STI_AW-1:0] W_ONE    = STI_AW'(1);
  localparam logic [RW-1:0]     LAST_ROW = RW'(IMG_H - 1);
  localparam logic [RW-1:0]     R_ONE    = RW'(1);
  localparam logic [CW-1:0]     LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     C_ONE    = CW'(1);
  localparam logic [KW-1:0]     LAST_BIT = KW'(STI_DW - 1);
  localparam logic [KW-1:0]     K_ONE    = KW'(1);

  // Each state names what the current cycle's registered outputs are doing.
  // *_C: centre read, *_N: neighbour read, *_W: result write.
  typedef enum logic [3:0] {
    S_IDLE, S_LD_RD, S_LD_WR, S_FW_C, S_FW_N, S_FW_W, S_FW_END,
    S_BW_C, S_BW_N, S_BW_W, S_DONE
  } state_t;

  state_t             state, state_n;
  logic               mode_r, mode_n;
  logic               busy_n, fw_n, done_n, sti_rd_n, res_rd_n, res_wr_n;
  logic [STI_AW-1:0]  sti_addr_n;
  logic [RES_AW-1:0]  res_addr_n, idx, idx_n;
  logic [PIX_W-1:0]   res_do_n, min_r, min_n, cen_r, cen_n;
  logic [RW-1:0]      row, row_n;
  logic [CW-1:0]      col, col_n;
  logic [KW-1:0]      bit_cnt, bit_n;
  logic [STI_DW-1:0]  word_buf, buf_n;
  logic [3:0]         pending, pend_n;

  // Neighbour slot bits. Forward: 0 NW, 1 N, 2 NE, 3 W.
  // Backward: 0 E, 1 SW, 2 S, 3 SE. City-block uses only the edge-sharing
  // slots.
  logic              bwd, c_state, top, bot, lft, rgt, oob;
  logic [3:0]        in_img, use_nb, need, pend_src, pend_left;
  logic [1:0]        sel;
  logic [RES_AW-1:0] nb_addr, adv_idx;
  logic [RW-1:0]     adv_row;
  logic [CW-1:0]     adv_col;
  logic              adv_last;
  logic [PIX_W-1:0]  min_start, m_cur, min_val, sat_v, cen_val, wr_val;
  logic [PIX_W:0]    inc;
  logic              do_adv, do_nb, do_wr;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0]) return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else return 2'd3;
  endfunction

  // Neighbour selection, pixel stepping and the min/saturate datapath.
  always_comb begin
    bwd     = (state == S_BW_C) || (state == S_BW_N) || (state == S_BW_W);
    c_state = (state == S_FW_C) || (state == S_BW_C);
    top = (row == '0);
    bot = (row == LAST_ROW);
    lft = (col == '0);
    rgt = (col == LAST_COL);
    if (bwd) begin
      in_img = {~bot & ~rgt, ~bot, ~bot & ~lft, ~rgt};
      use_nb = mode_r ? 4'b0101 : 4'b1111;
    end else begin
      in_img = {~lft, ~top & ~rgt, ~top, ~top & ~lft};
      use_nb = mode_r ? 4'b1010 : 4'b1111;
    end
    need = use_nb & in_img;
    // An out-of-image neighbour counts as 0, so the minimum starts at 0
    // instead of being fetched.
    oob       = |(use_nb & ~in_img);
    min_start = oob ? '0 : '1;
    pend_src  = c_state ? need : pending;
    sel       = lowest(pend_src);
    pend_left = pend_src & ~(4'b0001 << sel);
    case ({bwd, sel})
      3'b000:  nb_addr = idx - OFF_W - A_ONE;
      3'b001:  nb_addr = idx - OFF_W;
      3'b010:  nb_addr = idx - OFF_W + A_ONE;
      3'b011:  nb_addr = idx - A_ONE;
      3'b100:  nb_addr = idx + A_ONE;
      3'b101:  nb_addr = idx + OFF_W - A_ONE;
      3'b110:  nb_addr = idx + OFF_W;
      default: nb_addr = idx + OFF_W + A_ONE;
    endcase
    if (bwd) begin
      adv_last = (idx == '0);
      adv_idx  = idx - A_ONE;
      adv_col  = lft ? LAST_COL : col - C_ONE;
      adv_row  = lft ? row - R_ONE : row;
    end else begin
      adv_last = (idx == LAST_PIX);
      adv_idx  = idx + A_ONE;
      adv_col  = rgt ? '0 : col + C_ONE;
      adv_row  = rgt ? row + R_ONE : row;
    end
    m_cur   = (res_di < min_r) ? res_di : min_r;
    min_val = c_state ? min_start : m_cur;
    // One extra bit so that min+1 saturates instead of wrapping.
    inc     = {1'b0, min_val} + {{PIX_W{1'b0}}, 1'b1};
    sat_v   = inc[PIX_W] ? {PIX_W{1'b1}} : inc[PIX_W-1:0];
    cen_val = c_state ? res_di : cen_r;
    wr_val  = (bwd && (cen_val < sat_v)) ? cen_val : sat_v;
  end

  always_comb begin
    state_n = state;  mode_n = mode_r;
    busy_n = busy;    fw_n = fwpass_finish;  done_n = done;
    sti_rd_n = 1'b0;  sti_addr_n = sti_addr;
    res_rd_n = 1'b0;  res_wr_n = 1'b0;  res_addr_n = res_addr;  res_do_n = res_do;
    idx_n = idx;  row_n = row;  col_n = col;  bit_n = bit_cnt;  buf_n = word_buf;
    min_n = min_r;  cen_n = cen_r;  pend_n = pending;
    do_adv = 1'b0;  do_nb = 1'b0;  do_wr = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_n = mode;  busy_n = 1'b1;  fw_n = 1'b0;  done_n = 1'b0;
          sti_rd_n = 1'b1;  sti_addr_n = '0;  idx_n = '0;
          state_n = S_LD_RD;
        end
      end
      S_LD_RD: begin
        buf_n = sti_di << 1;  bit_n = '0;
        res_wr_n = 1'b1;  res_addr_n = idx;  res_do_n = PIX_W'(sti_di[STI_DW-1]);
        state_n = S_LD_WR;
      end
      S_LD_WR: begin
        if (bit_cnt != LAST_BIT) begin
          idx_n = idx + A_ONE;  bit_n = bit_cnt + K_ONE;  buf_n = word_buf << 1;
          res_wr_n = 1'b1;  res_addr_n = idx + A_ONE;
          res_do_n = PIX_W'(word_buf[STI_DW-1]);
        end else if (idx == LAST_PIX) begin
          idx_n = '0;  row_n = '0;  col_n = '0;
          res_rd_n = 1'b1;  res_addr_n = '0;
          state_n = S_FW_C;
        end else begin
          idx_n = idx + A_ONE;
          sti_rd_n = 1'b1;  sti_addr_n = sti_addr + W_ONE;
          state_n = S_LD_RD;
        end
      end
      S_FW_C, S_BW_C: begin
        if (res_di == '0) begin
          do_adv = 1'b1;
        end else begin
          cen_n = res_di;  min_n = min_start;
          if (pend_src != '0) do_nb = 1'b1;
          else do_wr = 1'b1;
        end
      end
      S_FW_N, S_BW_N: begin
        min_n = m_cur;
        if (pending != '0) do_nb = 1'b1;
        else do_wr = 1'b1;
      end
      S_FW_W, S_BW_W: do_adv = 1'b1;
      S_FW_END: begin
        idx_n = LAST_PIX;  row_n = LAST_ROW;  col_n = LAST_COL;
        res_rd_n = 1'b1;  res_addr_n = LAST_PIX;
        state_n = S_BW_C;
      end
      default: state_n = S_IDLE;
    endcase
    if (do_nb) begin
      res_rd_n = 1'b1;  res_addr_n = nb_addr;  pend_n = pend_left;
      state_n = bwd ? S_BW_N : S_FW_N;
    end
    if (do_wr) begin
      res_wr_n = 1'b1;  res_addr_n = idx;  res_do_n = wr_val;
      state_n = bwd ? S_BW_W : S_FW_W;
    end
    if (do_adv) begin
      if (adv_last && bwd) begin
        done_n = 1'b1;  busy_n = 1'b0;  state_n = S_DONE;
      end else if (adv_last) begin
        fw_n = 1'b1;  state_n = S_FW_END;
      end else begin
        idx_n = adv_idx;  row_n = adv_row;  col_n = adv_col;
        res_rd_n = 1'b1;  res_addr_n = adv_idx;
        state_n = bwd ? S_BW_C : S_FW_C;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;  mode_r <= 1'b0;
      busy <= 1'b0;  fwpass_finish <= 1'b0;  done <= 1'b0;
      sti_rd <= 1'b0;  sti_addr <= '0;
      res_rd <= 1'b0;  res_wr <= 1'b0;  res_addr <= '0;  res_do <= '0;
      idx <= '0;  row <= '0;  col <= '0;  bit_cnt <= '0;  word_buf <= '0;
      min_r <= '0;  cen_r <= '0;  pending <= '0;
    end else begin
      state <= state_n;  mode_r <= mode_n;
      busy <= busy_n;  fwpass_finish <= fw_n;  done <= done_n;
      sti_rd <= sti_rd_n;  sti_addr <= sti_addr_n;
      res_rd <= res_rd_n;  res_wr <= res_wr_n;  res_addr <= res_addr_n;  res_do <= res_do_n;
      idx <= idx_n;  row <= row_n;  col <= col_n;  bit_cnt <= bit_n;  word_buf <= buf_n;
      min_r <= min_n;  cen_r <= cen_n;  pending <= pend_n;
    end
  end

endmodule

// File: tb/tb_dt_engine_param.sv
// tb_dt_engine_param: bench for dt_engine_param on an 8x8 image, 8 pixels per
// ROM word, 2-bit distances (saturating at 3). It models the ROM and the RAM
// with negedge reads and posedge writes. Expected maps come from a
// neighbour-table reference of the two-pass distance transform.
module tb_dt_engine_param;
  localparam int IMG_W = 8, IMG_H = 8, STI_DW = 8, PIX_W = 2;
  localparam int NPIX = IMG_W * IMG_H, NWORD = NPIX / STI_DW;
  localparam int STI_AW = $clog2(NWORD), RES_AW = $clog2(NPIX);
  localparam int MAXV = (1 << PIX_W) - 1;
  localparam int LOAD_CYC = NWORD * (STI_DW + 1);

  // clock / reset / DUT
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, scramble = 1'b0;
  logic busy, fwpass_finish, done, sti_rd, res_rd, res_wr;
  logic [STI_AW-1:0] sti_addr;
  logic [STI_DW-1:0] sti_di = '0;
  logic [RES_AW-1:0] res_addr;
  logic [PIX_W-1:0]  res_do;
  logic [PIX_W-1:0]  res_di = '0;
  logic [31:0]       outs;

  always #5 clk = ~clk;

  dt_engine_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .STI_DW(STI_DW), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .fwpass_finish(fwpass_finish), .done(done),
    .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr),
    .res_do(res_do), .res_di(res_di)
  );

  assign outs = 32'({busy, fwpass_finish, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do});

  // memories
  logic [STI_DW-1:0] rom [NWORD];
  logic [PIX_W-1:0]  ram [NPIX];
  int rdwr_viol = 0;

  always @(negedge clk) begin
    if (sti_rd) sti_di <= rom[sti_addr];
    if (res_rd) res_di <= ram[res_addr];
  end

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= PIX_W'($urandom_range(0, MAXV));
    end else if (res_wr) begin
      ram[res_addr] <= res_do;
    end
    if (res_rd && res_wr) rdwr_viol <= rdwr_viol + 1;
  end

  // scoreboard / reference model
  int img [NPIX];
  int exp_fwd [NPIX];
  int exp_fin [NPIX];
  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Neighbour value, with anything outside the image reading as 0.
  function automatic int nb_val(input int r, input int c, input bit fin);
    if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return 0;
    return fin ? exp_fin[r * IMG_W + c] : exp_fwd[r * IMG_W + c];
  endfunction

  task automatic build_model(input int m);
    int dr [4];
    int dc [4];
    int n, r, c, best;
    if (m == 0) begin n = 4; dr = '{-1, -1, -1, 0}; dc = '{-1, 0, 1, -1}; end
    else begin n = 2; dr = '{-1, 0, 0, 0}; dc = '{0, -1, 0, 0}; end
    for (int i = 0; i < NPIX; i++) begin
      r = i / IMG_W; c = i % IMG_W;
      if (img[i] == 0) exp_fwd[i] = 0;
      else begin
        best = 1 << 30;
        for (int k = 0; k < n; k++) best = min2(best, nb_val(r + dr[k], c + dc[k], 1'b0));
        exp_fwd[i] = min2(best + 1, MAXV);
      end
    end
    for (int i = 0; i < NPIX; i++) exp_fin[i] = exp_fwd[i];
    if (m == 0) begin n = 4; dr = '{0, 1, 1, 1}; dc = '{1, -1, 0, 1}; end
    else begin n = 2; dr = '{0, 1, 0, 0}; dc = '{1, 0, 0, 0}; end
    for (int i = NPIX - 1; i >= 0; i--) begin
      r = i / IMG_W; c = i % IMG_W;
      if (exp_fin[i] != 0) begin
        best = 1 << 30;
        for (int k = 0; k < n; k++) best = min2(best, nb_val(r + dr[k], c + dc[k], 1'b1));
        exp_fin[i] = min2(exp_fin[i], min2(best + 1, MAXV));
      end
    end
  endtask

  // driver tasks
  task automatic set_img(input int kind);
    int thr, r, c;
    thr = $urandom_range(20, 95);
    for (int i = 0; i < NPIX; i++) begin
      r = i / IMG_W; c = i % IMG_W;
      case (kind)
        0: img[i] = 0;
        1: img[i] = (r == 3 && c == 3) ? 1 : 0;
        2: img[i] = (r >= 2 && r <= 4 && c >= 2 && c <= 4) ? 1 : 0;
        3: img[i] = 1;
        default: img[i] = ($urandom_range(0, 99) < thr) ? 1 : 0;
      endcase
    end
    for (int w = 0; w < NWORD; w++)
      for (int k = 0; k < STI_DW; k++)
        rom[w][STI_DW-1-k] = (img[w * STI_DW + k] != 0);
  endtask

  task automatic pulse_start(input bit m);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = ~m;
  endtask

  task automatic wait_flag(input bit want_done, input int bound, output int cyc);
    cyc = 0;
    while (!(want_done ? done : fwpass_finish) && cyc < bound) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic run(input string name, input bit m, input bit poke);
    int obj, lim, cyc, viol0;
    obj = 0;
    for (int i = 0; i < NPIX; i++) obj += (img[i] != 0) ? 1 : 0;
    build_model(int'(m));
    @(negedge clk); scramble = 1'b1;
    @(negedge clk); scramble = 1'b0;
    viol0 = rdwr_viol;
    pulse_start(m);
    check({name, "_start_flags"}, 32'({busy, fwpass_finish, done}), 32'(3'b100));
    lim = LOAD_CYC + 6 * obj + (NPIX - obj);
    wait_flag(1'b0, lim + 8, cyc);
    check({name, "_fw_flag"}, 32'(fwpass_finish), 32'd1);
    check({name, "_fw_cycles_ok"}, 32'(cyc <= lim), 32'd1);
    check({name, "_fw_busy_done"}, 32'({busy, done}), 32'(2'b10));
    for (int i = 0; i < NPIX; i++)
      check($sformatf("%s_fwd[%0d]", name, i), 32'(ram[i]), 32'(exp_fwd[i]));
    if (poke) begin
      // start with the other mode while the backward pass runs: must be ignored
      pulse_start(~m);
      check({name, "_poke_ignored"}, 32'({busy, fwpass_finish, done}), 32'(3'b110));
    end
    lim = 1 + 6 * obj + (NPIX - obj);
    wait_flag(1'b1, lim + 8, cyc);
    if (poke) cyc += 2;
    check({name, "_done_flags"}, 32'({busy, fwpass_finish, done}), 32'(3'b011));
    check({name, "_bw_cycles_ok"}, 32'(cyc <= lim), 32'd1);
    check({name, "_rd_wr_excl"}, 32'(rdwr_viol - viol0), 32'd0);
    for (int i = 0; i < NPIX; i++)
      check($sformatf("%s_fin[%0d]", name, i), 32'(ram[i]), 32'(exp_fin[i]));
  endtask

  // main sequence
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs, 32'd0);

    set_img(0); run("zero", 1'b0, 1'b0);
    set_img(1); run("single", 1'b0, 1'b0);
    set_img(2); run("blk_cb", 1'b0, 1'b0);
    run("blk_city", 1'b1, 1'b0);
    set_img(3); run("ones_cb", 1'b0, 1'b0);
    run("ones_city", 1'b1, 1'b0);

    // abort in the middle of the forward pass, then rebuild from scratch
    set_img(2);
    pulse_start(1'b0);
    repeat (LOAD_CYC + 20) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("reset_mid_fwd", outs, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("idle_after_abort", outs, 32'd0);
    run("blk_rerun", 1'b0, 1'b0);

    set_img(4); run("poke", 1'b0, 1'b1);
    run("after_poke", 1'b1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      set_img(4);
      run($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
